memory_bus_responder: RTL and testbench

MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

---
 rtl/memory_map_pkg.sv | 33 +++
 rtl/output_fifo.sv | 71 +++++++
 rtl/memory_bus_responder.sv | 112 +++++++++++
 tb/tb_memory_bus_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_map_pkg.sv
// Shared register map of the memory bus responder: MMIO register offsets,
// STATUS bit layout and output FIFO depth.
package memory_map_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CountWidth = $clog2(FIFO_DEPTH + 1);

    // Register offsets relative to MMIO_BASE
    typedef enum logic [1:0] {
        RegOutData = 2'd0,
        RegStatus  = 2'd1,
        RegCycleLo = 2'd2,
        RegCycleHi = 2'd3
    } reg_sel_e;

    localparam int unsigned StatusFullBit  = 0;
    localparam int unsigned StatusEmptyBit = 1;
    localparam int unsigned StatusOvfBit   = 2;
    localparam int unsigned StatusCountLsb = 3;

    function automatic logic [15:0] pack_status(input logic full, input logic empty,
                                                input logic ovf,
                                                input logic [CountWidth-1:0] count);
        logic [15:0] s;
        s = '0;
        s[StatusFullBit]                   = full;
        s[StatusEmptyBit]                  = empty;
        s[StatusOvfBit]                    = ovf;
        s[StatusCountLsb +: CountWidth]    = count;
        return s;
    endfunction

endpackage

// File: rtl/output_fifo.sv
// FIFO_DEPTH-entry registered FIFO; a push into a full FIFO is accepted only
// when a pop happens at the same edge.
module output_fifo
    import memory_map_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [Width-1:0]      data_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CountWidth-1:0] count_o,
    output logic [Width-1:0]      data_o
);

    localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);

    logic [Width-1:0]      mem_q [FIFO_DEPTH];
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  do_pop, do_push;

    assign full_o  = (count_q == CountWidth'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CountWidth'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CountWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/memory_bus_responder.sv
// Single-cycle CPU bus responder: RAM, a small MMIO register window with an
// output FIFO, overflow flag and a 32-bit cycle counter with snapshot read.
module memory_bus_responder
    import memory_map_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 12,
    parameter logic [15:0] MMIO_BASE      = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_write_enable,
    input  logic [15:0] memory_address,
    input  logic [15:0] memory_write_data,
    output logic [15:0] memory_read_data,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready
);

    localparam int unsigned RamWords = 2 ** RAM_ADDR_WIDTH;

    logic [15:0] ram_q [RamWords];
    logic [15:0] rdata_q, rdata_d;
    logic        ovf_q, ovf_d;
    logic [31:0] cycle_q;
    logic [15:0] hi_q, hi_d;

    logic [15:0]           mmio_off;
    logic                  mmio_hit, ram_hit, ram_we;
    logic                  fifo_push, fifo_full, fifo_empty;
    logic [CountWidth-1:0] fifo_count;
    logic                  ovf_set, ovf_clr, hi_latch;

    assign mmio_off = memory_address - MMIO_BASE;
    assign mmio_hit = (mmio_off < 16'd4);
    assign ram_hit  = (32'(memory_address) < RamWords) && !mmio_hit;
    assign ram_we   = memory_write_enable && ram_hit;

    always_comb begin
        rdata_d   = '0;
        fifo_push = 1'b0;
        ovf_clr   = 1'b0;
        hi_latch  = 1'b0;
        if (mmio_hit) begin
            unique case (reg_sel_e'(mmio_off[1:0]))
                RegOutData: fifo_push = memory_write_enable;
                RegStatus: begin
                    rdata_d = pack_status(fifo_full, fifo_empty, ovf_q, fifo_count);
                    ovf_clr = memory_write_enable && memory_write_data[StatusOvfBit];
                end
                RegCycleLo: begin
                    rdata_d  = cycle_q[15:0];
                    hi_latch = 1'b1;
                end
                RegCycleHi: rdata_d = hi_q;
            endcase
        end else if (ram_hit) begin
            rdata_d = ram_q[memory_address[RAM_ADDR_WIDTH-1:0]];
        end
    end

    // A push into a full FIFO is dropped unless the peripheral pops at the same edge.
    assign ovf_set = fifo_push && fifo_full && !out_ready;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        hi_d = hi_latch ? cycle_q[31:16] : hi_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            cycle_q <= '0;
            hi_q    <= '0;
        end else begin
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            cycle_q <= cycle_q + 32'd1;
            hi_q    <= hi_d;
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_q[memory_address[RAM_ADDR_WIDTH-1:0]] <= memory_write_data;
        end
    end

    output_fifo #(
        .Width(16)
    ) u_output_fifo (
        .clk_i  (clock),
        .rst_ni (reset),
        .push_i (fifo_push),
        .pop_i  (out_ready),
        .data_i (memory_write_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count),
        .data_o (out_data)
    );

    assign memory_read_data = rdata_q;
    assign out_valid        = !fifo_empty;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Randomised and directed bench for memory_bus_responder, checked every cycle
// against a queue-based behavioural model.
module tb_memory_bus_responder;

    localparam logic [15:0] Base = 16'hFF00;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b1;

    memory_bus_responder #(
        .RAM_ADDR_WIDTH(12),
        .MMIO_BASE     (Base)
    ) dut (
        .clock              (clk),
        .reset              (rst_n),
        .memory_write_enable(we),
        .memory_address     (addr),
        .memory_write_data  (wdata),
        .memory_read_data   (rdata),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_ready          (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] ram_m [int];
    logic [15:0] q_m [$];
    bit          ovf_m = 1'b0;
    int unsigned cnt_m = 0;
    int unsigned last_cnt_m = 0;
    logic [15:0] hi_m = '0;
    logic [15:0] rd_m = '0;
    bit          rd_known_m = 1'b1;
    logic [15:0] t_off;
    bit          t_pop, t_push, t_set, t_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_m.delete();
            ovf_m      = 1'b0;
            cnt_m      = 0;
            hi_m       = '0;
            rd_m       = '0;
            rd_known_m = 1'b1;
        end else begin
            t_pop      = (q_m.size() > 0) && out_ready;
            t_push     = 1'b0;
            t_set      = 1'b0;
            t_clr      = 1'b0;
            t_off      = addr - Base;
            rd_m       = '0;
            rd_known_m = 1'b1;
            if (t_off < 16'd4) begin
                case (t_off)
                    16'd0: begin
                        if (we) begin
                            if (q_m.size() < 4 || t_pop) t_push = 1'b1;
                            else t_set = 1'b1;
                        end
                    end
                    16'd1: begin
                        rd_m = 16'((q_m.size() == 4) + 2 * (q_m.size() == 0) + 4 * ovf_m
                                   + 8 * q_m.size());
                        t_clr = we && wdata[2];
                    end
                    16'd2: begin
                        rd_m = cnt_m[15:0];
                        hi_m = cnt_m[31:16];
                    end
                    default: rd_m = hi_m;
                endcase
            end else if (addr < 16'd4096) begin
                rd_known_m = ram_m.exists(int'(addr));
                rd_m       = rd_known_m ? ram_m[int'(addr)] : 16'h0;
                if (we) ram_m[int'(addr)] = wdata;
            end
            if (t_pop) void'(q_m.pop_front());
            if (t_push) q_m.push_back(wdata);
            if (t_clr) ovf_m = 1'b0;
            if (t_set) ovf_m = 1'b1;
            last_cnt_m = cnt_m;
            cnt_m      = cnt_m + 1;
        end
    end

    // Compare process: outputs checked on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (rd_known_m) check("rdata", {16'h0, rdata}, {16'h0, rd_m});
            check("out_valid", {31'h0, out_valid}, {31'h0, q_m.size() != 0});
            if (q_m.size() != 0) check("out_data", {16'h0, out_data}, {16'h0, q_m[0]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input bit w, input logic [15:0] a, input logic [15:0] d, input bit rdy);
        @(negedge clk);
        we        = w;
        addr      = a;
        wdata     = d;
        out_ready = rdy;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus();
        int r;
        logic [15:0] a;
        r = $urandom_range(0, 99);
        if (r < 40) a = 16'($urandom_range(0, 15));
        else if (r < 50) a = 16'($urandom_range(4088, 4095));
        else if (r < 85) a = Base + 16'($urandom_range(0, 3));
        else if (r < 93) a = 16'($urandom_range(16'h1000, 16'hFEFF));
        else a = 16'($urandom_range(16'hFF04, 16'hFFFF));
        bus(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 9) < 4);
    endtask

    logic [15:0] lo_v, hi_v;
    int unsigned cap;

    initial begin
        rst_n     = 1'b0;
        we        = 1'b0;
        addr      = 16'h0;
        wdata     = 16'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_rdata", {16'h0, rdata}, 32'h0);
        check("reset_valid", {31'h0, out_valid}, 32'h0);

        bus(1'b0, Base + 16'd1, 16'h0, 1'b0);
        settle();
        check("status_after_reset", {16'h0, rdata}, 32'h0002);

        // RAM write then read of the same word
        bus(1'b1, 16'd5, 16'h1234, 1'b0);
        settle();
        bus(1'b0, 16'd5, 16'h0, 1'b0);
        settle();
        check("ram_rd_after_wr", {16'h0, rdata}, 32'h1234);

        // Five pushes with no drain: fifth dropped, overflow set
        for (int i = 1; i <= 5; i++) bus(1'b1, Base, 16'(i), 1'b0);
        bus(1'b0, Base + 16'd1, 16'h0, 1'b0);
        settle();
        check("status_full_ovf", {16'h0, rdata}, 32'h0025);
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", {31'h0, out_valid}, 32'h1);
            check("drain_data", {16'h0, out_data}, i);
            bus(1'b0, 16'h8000, 16'h0, 1'b1);
            settle();
        end
        check("drain_empty", {31'h0, out_valid}, 32'h0);

        // Clear overflow, refill, then push while popping at full
        bus(1'b1, Base + 16'd1, 16'h0004, 1'b0);
        for (int i = 0; i < 4; i++) bus(1'b1, Base, 16'h0011 + 16'(i), 1'b0);
        bus(1'b1, Base, 16'hAAAA, 1'b1);
        bus(1'b0, Base + 16'd1, 16'h0, 1'b0);
        settle();
        check("status_push_pop_full", {16'h0, rdata}, 32'h0021);
        for (int i = 0; i < 4; i++) begin
            check("pp_data", {16'h0, out_data}, (i == 3) ? 32'hAAAA : 32'h12 + i);
            bus(1'b0, 16'h8000, 16'h0, 1'b1);
            settle();
        end
        check("pp_empty", {31'h0, out_valid}, 32'h0);

        // Random traffic until the cycle counter has passed 16'hFFFF
        while (cnt_m < 32'h0001_0010) rand_bus();

        bus(1'b0, Base + 16'd2, 16'h0, 1'b0);
        settle();
        lo_v = rdata;
        cap  = last_cnt_m;
        bus(1'b0, Base + 16'd3, 16'h0, 1'b0);
        settle();
        hi_v = rdata;
        check("cycle_pair", {hi_v, lo_v}, cap);
        check("cycle_hi_nonzero", {31'h0, hi_v != 16'h0}, 32'h1);

        // Mid-cycle asynchronous reset with three entries held
        bus(1'b1, Base + 16'd1, 16'h0004, 1'b0);
        bus(1'b1, 16'd5, 16'h1234, 1'b0);
        for (int i = 0; i < 3; i++) bus(1'b1, Base, 16'h0070 + 16'(i), 1'b0);
        bus(1'b0, 16'd5, 16'h0, 1'b0);
        settle();
        check("pre_reset_rdata", {16'h0, rdata}, 32'h1234);
        check("pre_reset_valid", {31'h0, out_valid}, 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, out_valid}, 32'h0);
        check("async_rst_rdata", {16'h0, rdata}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus(1'b0, Base + 16'd1, 16'h0, 1'b0);
        settle();
        check("status_after_rst", {16'h0, rdata}, 32'h0002);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
